// File: rtl/fir_ntap_pkg.sv
// fir_ntap_pkg: shared width helpers and coefficient defaults for fir_ntap_stream (clipping option: FIR_NTAP_SAT_EN)
package fir_ntap_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction
  function automatic int def_coef(input int i);
    return i + 1;
  endfunction
  function automatic int level_n(input int n, input int l);
    int r = n;
    for (int k = 0; k < l; k++) r = (r + 1) / 2;
    return r;
  endfunction
  function automatic int tree_extra_lat(input int n);
    return (n > 8) ? 1 : 0;
  endfunction
endpackage

// File: rtl/fir_add_tree.sv
// fir_add_tree: registered binary adder tree; odd leftovers pass through, wide trees add retiming levels
module fir_add_tree import fir_ntap_pkg::*; #(
  parameter int N = 4,
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_data [N],
  output logic         o_valid,
  output logic [W-1:0] o_sum
);
  localparam int LVL = clog2(N);
  localparam int EXTRA_LAT = tree_extra_lat(N);
  logic [W-1:0] w_node [LVL+1][N];
  logic [W-1:0] r_sum [EXTRA_LAT+1];
  logic [EXTRA_LAT:0] r_v;
  for (genvar j = 0; j < N; j++) begin : g_leaf
    assign w_node[0][j] = i_data[j];
  end
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    for (genvar j = 0; j < N; j++) begin : g_node
      if (j < level_n(N, l + 1)) begin : g_live
        if (2 * j + 1 < level_n(N, l)) begin : g_add
          assign w_node[l+1][j] = w_node[l][2*j] + w_node[l][2*j+1];
        end else begin : g_pass
          assign w_node[l+1][j] = w_node[l][2*j];
        end
      end else begin : g_dead
        assign w_node[l+1][j] = '0;
      end
    end
  end
  // Sum register followed by any retiming levels; everything freezes while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k <= EXTRA_LAT; k++) r_sum[k] <= '0;
    end else if (i_en) begin
      r_v <= (EXTRA_LAT + 1)'({r_v, i_valid});
      r_sum[0] <= w_node[LVL][0];
      for (int k = 1; k <= EXTRA_LAT; k++) r_sum[k] <= r_sum[k-1];
    end
  end
  assign o_valid = r_v[EXTRA_LAT];
  assign o_sum = r_sum[EXTRA_LAT];
endmodule

// File: rtl/fir_ntap_stream.sv
// fir_ntap_stream: pipelined unsigned FIR with valid/ready stream and writable coefficients (clipping option: FIR_NTAP_SAT_EN)
module fir_ntap_stream import fir_ntap_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS = 4,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   coef_we,
  input  logic [clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]      coef_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
  localparam int P_W = DATA_W + COEF_W;
  logic [DATA_W-1:0] r_x [TAPS];
  logic [COEF_W-1:0] r_c [TAPS];
  logic [P_W-1:0] r_p [TAPS];
  logic [ACC_W-1:0] w_p [TAPS];
  logic [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0] w_next, r_out_data;
  logic r_xv, r_v1, w_v2, r_out_valid, r_sat, w_clip, w_stall, w_accept;
  assign w_stall = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  // Delay line advances only on an accepted sample; r_xv flags a fresh sample for S1
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
      r_xv <= 1'b0;
    end else if (!w_stall) begin
      r_xv <= w_accept;
      if (w_accept) begin
        r_x[0] <= in_data;
        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
      end
    end
  end
  // Coefficient bank: reset to 1..TAPS, out-of-range addresses dropped, writable even while stalled
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < TAPS; i++) r_c[i] <= COEF_W'(def_coef(i));
    else if (coef_we && int'(coef_addr) < TAPS) r_c[coef_addr] <= coef_data;
  end
  // S1: full-width products of the delay line and the current coefficients
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_p[i] <= '0;
    end else if (!w_stall) begin
      r_v1 <= r_xv;
      for (int i = 0; i < TAPS; i++) r_p[i] <= P_W'(r_x[i]) * P_W'(r_c[i]);
    end
  end
  for (genvar i = 0; i < TAPS; i++) begin : g_ext
    assign w_p[i] = ACC_W'(r_p[i]);
  end
  fir_add_tree #(.N(TAPS), .W(ACC_W)) u_tree (
    .clk(clk),
    .rst(rst),
    .i_en(!w_stall),
    .i_valid(r_v1),
    .i_data(w_p),
    .o_valid(w_v2),
    .o_sum(w_sum)
  );
`ifdef FIR_NTAP_SAT_EN
  logic [ACC_W-1:0] w_shr;
  assign w_shr = w_sum >> SHIFT;
  assign w_clip = |(w_shr >> OUT_W);
  assign w_next = w_clip ? '1 : OUT_W'(w_shr);
`else
  assign w_clip = 1'b0;
  assign w_next = OUT_W'(w_sum >> SHIFT);
`endif
  // S3: scaled and narrowed output, held stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_sat <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_v2;
      r_out_data <= w_next;
      r_sat <= w_clip;
    end
  end
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  assign out_sat = r_sat;
endmodule

// File: tb/tb_fir_ntap_stream.sv
// tb_fir_ntap_stream: directed and random checks of fir_ntap_stream against a behavioural FIR model
module tb_fir_ntap_stream;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, coef_we = 0, coef_we2 = 0;
  logic [7:0] in_data = 0, coef_data = 0, coef_data2 = 0;
  logic [1:0] coef_addr = 0;
  logic [2:0] coef_addr2 = 0;
  logic in_ready, out_valid, out_sat, in_ready2, out_valid2, out_sat2;
  logic [7:0] out_data, out_data2;
  int total = 0, bad = 0, cyc = 0;
  int exp_q[$], exp_sat_q[$], acc_q[$], got_q[$], got_sat_q[$], lat_q[$], got2_q[$];
  int hist[4], mc[4];
  logic stall_prev = 0, prev_sat = 0;
  logic [7:0] prev_data = 0;

  fir_ntap_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );
  fir_ntap_stream #(.TAPS(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_data(coef_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic void model_push();
    int acc = 0;
    for (int i = 0; i < 4; i++) acc += mc[i] * hist[i];
`ifdef FIR_NTAP_SAT_EN
    exp_q.push_back(acc > 255 ? 255 : acc);
    exp_sat_q.push_back(acc > 255 ? 1 : 0);
`else
    exp_q.push_back(acc % 256);
    exp_sat_q.push_back(0);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); exp_sat_q.delete(); acc_q.delete();
      for (int i = 0; i < 4; i++) begin hist[i] = 0; mc[i] = i + 1; end
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_sat", out_sat, prev_sat);
      end
      check("in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
        else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_sat", out_sat, exp_sat_q.pop_front());
          got_q.push_back(out_data);
          got_sat_q.push_back(out_sat);
          lat_q.push_back(cyc - acc_q.pop_front());
        end
      end
      if (coef_we) mc[coef_addr] = coef_data;
      if (in_valid && in_ready) begin
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_data;
        model_push();
        acc_q.push_back(cyc + 1);
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_sat = out_sat;
      if (out_valid2 && out_ready) got2_q.push_back(out_data2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    int n = 0;
    in_valid = 1;
    in_data = 8'(d);
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    out_ready = 1;
    while (exp_q.size() != 0 && n < 60) begin n++; tick(); end
    check("drain_left", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic flush();
    repeat (6) send(0);
    drain();
    got_q.delete(); got_sat_q.delete(); lat_q.delete(); got2_q.delete();
  endtask

  task automatic cmp_seq(input string name, input int got[$], input int want[$]);
    check({name, "_len"}, got.size(), want.size());
    foreach (want[i]) if (i < got.size()) check(name, got[i], want[i]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: cycle=%0d required finish", cyc);
    $fatal(1);
  end

  initial begin
    int ref_q[$];
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(1); repeat (4) send(0);
    drain();
    cmp_seq("impulse", got_q, '{1, 2, 3, 4, 0});
    cmp_seq("impulse_lat", lat_q, '{3, 3, 3, 3, 3});
    flush();
    repeat (5) send(10);
    drain();
    cmp_seq("step", got_q, '{10, 30, 60, 100, 100});
    flush();
    repeat (6) send(255);
    drain();
`ifdef FIR_NTAP_SAT_EN
    cmp_seq("sat", got_q, '{255, 255, 255, 255, 255, 255});
    cmp_seq("sat_flag", got_sat_q, '{0, 1, 1, 1, 1, 1});
`else
    cmp_seq("sat", got_q, '{255, 253, 250, 246, 246, 246});
    cmp_seq("sat_flag", got_sat_q, '{0, 0, 0, 0, 0, 0});
`endif
    flush();
    for (int i = 0; i < 10; i++) send(i * 17 + 3);
    drain();
    ref_q = got_q;
    flush();
    fork
      for (int i = 0; i < 10; i++) send(i * 17 + 3);
      begin
        repeat (4) tick();
        out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();
    cmp_seq("bp_seq", got_q, ref_q);
    flush();
    coef_we = 1; coef_addr = 0; coef_data = 5;
    coef_we2 = 1; coef_addr2 = 0; coef_data2 = 5;
    tick();
    coef_we = 0;
    coef_addr2 = 7; coef_data2 = 99;
    tick();
    coef_addr2 = 6;
    tick();
    coef_we2 = 0;
    send(1); repeat (6) send(0);
    drain();
    cmp_seq("coef_wr", got_q, '{5, 2, 3, 4, 0, 0, 0});
    cmp_seq("coef_wr6", got2_q, '{5, 2, 3, 4, 5, 6, 0});
    flush();
    fork
      for (int i = 0; i < 8; i++) send(i * 9 + 1);
      begin
        repeat (4) tick();
        coef_we = 1; coef_addr = 1; coef_data = 7;
        tick();
        coef_we = 0;
      end
    join
    drain();
    check("simul_len", got_q.size(), 8);
    flush();
    send(7); send(8); send(9);
    rst = 1;
    tick();
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    check("rst_mid_count", got_q.size(), 0);
    send(1); repeat (3) send(0);
    drain();
    cmp_seq("rst_impulse", got_q, '{1, 2, 3, 4});
    for (int b = 0; b < 6; b++) begin
      drain();
      repeat ($urandom_range(1, 3)) begin
        coef_we = 1;
        coef_addr = 2'($urandom_range(0, 3));
        coef_data = 8'($urandom);
        tick();
      end
      coef_we = 0;
      for (int c = 0; c < 150; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        rst = (b == 3 && c == 70);
        tick();
      end
      rst = 0;
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
